// File: rtl/id_ex_pipeline_reg_if.sv
// id_ex_pipeline_reg_if: decode-side inputs, WB write-through and EX-side outputs of the ID/EX register
interface id_ex_pipeline_reg_if #(
  parameter int XLEN = 32,
  parameter int SEL_W = 5
);
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic             id_op1_sel;
  logic             id_op2_sel;
  logic [SEL_W-1:0] id_alu_select;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_reg_write;
  logic             id_branch;
  logic             id_jump;
  logic [2:0]       id_funct3;
  logic [1:0]       id_wb_sel;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             load_use_hazard;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_data1;
  logic [XLEN-1:0]  ex_data2;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [SEL_W-1:0] ex_alu_select;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_branch;
  logic             ex_jump;
  logic [2:0]       ex_funct3;
  logic [1:0]       ex_wb_sel;
  modport master (
    output stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_op1_sel, id_op2_sel, id_alu_select, id_mem_read, id_mem_write, id_reg_write, id_branch,
           id_jump, id_funct3, id_wb_sel, wb_reg_write, wb_rd, wb_data,
    input  load_use_hazard, ex_valid, ex_pc, ex_imm, ex_data1, ex_data2, ex_rs2_data, ex_rs1, ex_rs2,
           ex_rd, ex_alu_select, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_funct3, ex_wb_sel
  );
  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_op1_sel, id_op2_sel, id_alu_select, id_mem_read, id_mem_write, id_reg_write, id_branch,
           id_jump, id_funct3, id_wb_sel, wb_reg_write, wb_rd, wb_data,
    output load_use_hazard, ex_valid, ex_pc, ex_imm, ex_data1, ex_data2, ex_rs2_data, ex_rs1, ex_rs2,
           ex_rd, ex_alu_select, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_funct3, ex_wb_sel
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX register with operand select, WB write-through, stall refresh and load-use bubbling
module id_ex_pipeline_reg #(
  parameter int XLEN = 32,
  parameter int SEL_W = 5
) (
  input logic               i_clk,
  input logic               i_rst,
  id_ex_pipeline_reg_if.slave bus
);
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1v;
    logic [XLEN-1:0]  rs2v;
    logic             op1_sel;
    logic             op2_sel;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [SEL_W-1:0] alu_sel;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             branch;
    logic             jump;
    logic [2:0]       funct3;
    logic [1:0]       wb_sel;
  } ex_t;
  ex_t  r_ex;
  ex_t  w_cap;
  ex_t  w_held;
  ex_t  w_nxt;
  logic w_wb_ok;
  logic w_hazard;
  assign w_wb_ok  = bus.wb_reg_write && bus.wb_rd != 5'd0;
  assign w_hazard = r_ex.valid && r_ex.mem_read && r_ex.rd != 5'd0 && bus.id_valid &&
                    (r_ex.rd == bus.id_rs1 || r_ex.rd == bus.id_rs2);
  // capture image: decoded fields with WB write-through applied to the raw operands
  always_comb begin
    w_cap           = '0;
    w_cap.valid     = 1'b1;
    w_cap.pc        = bus.id_pc;
    w_cap.imm       = bus.id_imm;
    w_cap.rs1v      = w_wb_ok && bus.wb_rd == bus.id_rs1 ? bus.wb_data : bus.id_rs1_data;
    w_cap.rs2v      = w_wb_ok && bus.wb_rd == bus.id_rs2 ? bus.wb_data : bus.id_rs2_data;
    w_cap.op1_sel   = bus.id_op1_sel;
    w_cap.op2_sel   = bus.id_op2_sel;
    w_cap.rs1       = bus.id_rs1;
    w_cap.rs2       = bus.id_rs2;
    w_cap.rd        = bus.id_rd;
    w_cap.alu_sel   = bus.id_alu_select;
    w_cap.mem_read  = bus.id_mem_read;
    w_cap.mem_write = bus.id_mem_write;
    w_cap.reg_write = bus.id_reg_write && bus.id_rd != 5'd0;
    w_cap.branch    = bus.id_branch;
    w_cap.jump      = bus.id_jump;
    w_cap.funct3    = bus.id_funct3;
    w_cap.wb_sel    = bus.id_wb_sel;
  end
  // held image: a stalled entry keeps picking up WB results for its source registers
  always_comb begin
    w_held      = r_ex;
    w_held.rs1v = r_ex.valid && w_wb_ok && bus.wb_rd == r_ex.rs1 ? bus.wb_data : r_ex.rs1v;
    w_held.rs2v = r_ex.valid && w_wb_ok && bus.wb_rd == r_ex.rs2 ? bus.wb_data : r_ex.rs2v;
  end
  assign w_nxt = bus.flush ? '0 : bus.stall ? w_held : (w_hazard || !bus.id_valid) ? '0 : w_cap;
  // state register; a bubble is the all-zero image
  always_ff @(posedge i_clk) begin
    r_ex <= i_rst ? '0 : w_nxt;
  end
  assign bus.load_use_hazard = w_hazard;
  assign bus.ex_valid        = r_ex.valid;
  assign bus.ex_pc           = r_ex.pc;
  assign bus.ex_imm          = r_ex.imm;
  assign bus.ex_data1        = r_ex.op1_sel ? r_ex.pc : r_ex.rs1v;
  assign bus.ex_data2        = r_ex.op2_sel ? r_ex.imm : r_ex.rs2v;
  assign bus.ex_rs2_data     = r_ex.rs2v;
  assign bus.ex_rs1          = r_ex.rs1;
  assign bus.ex_rs2          = r_ex.rs2;
  assign bus.ex_rd           = r_ex.rd;
  assign bus.ex_alu_select   = r_ex.alu_sel;
  assign bus.ex_mem_read     = r_ex.mem_read;
  assign bus.ex_mem_write    = r_ex.mem_write;
  assign bus.ex_reg_write    = r_ex.reg_write;
  assign bus.ex_branch       = r_ex.branch;
  assign bus.ex_jump         = r_ex.jump;
  assign bus.ex_funct3       = r_ex.funct3;
  assign bus.ex_wb_sel       = r_ex.wb_sel;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed vectors with a queued scoreboard for the ID/EX register
module tb_id_ex_pipeline_reg;
  typedef struct {
    logic rst, stall, flush, valid, op1, op2, mr, mw, rw, br, jp, wbw;
    logic [31:0] pc, imm, rs1d, rs2d, wbd;
    logic [4:0] rs1, rs2, rd, sel, wbrd;
    logic [2:0] f3;
    logic [1:0] wb;
  } stim_t;
  typedef struct {
    int id;
    logic hz, valid, mr, mw, rw, br, jp;
    logic [31:0] pc, imm, d1, d2, rs2d;
    logic [4:0] rs1, rs2, rd, sel;
    logic [2:0] f3;
    logic [1:0] wb;
  } exp_t;
  logic clk;
  logic rst;
  id_ex_pipeline_reg_if bus ();
  id_ex_pipeline_reg dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  exp_t q[$];
  stim_t s;
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int step = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step %0d %s: got %h expected %h", id, nm, got, want);
    end
  endtask
  task automatic apply(input stim_t v);
    rst = v.rst; bus.stall = v.stall; bus.flush = v.flush; bus.id_valid = v.valid;
    bus.id_pc = v.pc; bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2; bus.id_rd = v.rd;
    bus.id_rs1_data = v.rs1d; bus.id_rs2_data = v.rs2d; bus.id_imm = v.imm;
    bus.id_op1_sel = v.op1; bus.id_op2_sel = v.op2; bus.id_alu_select = v.sel;
    bus.id_mem_read = v.mr; bus.id_mem_write = v.mw; bus.id_reg_write = v.rw;
    bus.id_branch = v.br; bus.id_jump = v.jp; bus.id_funct3 = v.f3; bus.id_wb_sel = v.wb;
    bus.wb_reg_write = v.wbw; bus.wb_rd = v.wbrd; bus.wb_data = v.wbd;
  endtask
  task automatic drive();
    @(posedge clk);
    #2;
    apply(s);
    step++;
    e.id = step;
    q.push_back(e);
  endtask
  initial begin
    exp_t c;
    forever begin
      while (q.size() == 0) #1;
      c = q.pop_front();
      @(negedge clk);
      chk(c.id, "load_use_hazard", {31'd0, bus.load_use_hazard}, {31'd0, c.hz});
      @(posedge clk);
      #1;
      chk(c.id, "ex_valid", {31'd0, bus.ex_valid}, {31'd0, c.valid});
      chk(c.id, "ex_pc", bus.ex_pc, c.pc);
      chk(c.id, "ex_imm", bus.ex_imm, c.imm);
      chk(c.id, "ex_data1", bus.ex_data1, c.d1);
      chk(c.id, "ex_data2", bus.ex_data2, c.d2);
      chk(c.id, "ex_rs2_data", bus.ex_rs2_data, c.rs2d);
      chk(c.id, "ex_rs1", {27'd0, bus.ex_rs1}, {27'd0, c.rs1});
      chk(c.id, "ex_rs2", {27'd0, bus.ex_rs2}, {27'd0, c.rs2});
      chk(c.id, "ex_rd", {27'd0, bus.ex_rd}, {27'd0, c.rd});
      chk(c.id, "ex_alu_select", {27'd0, bus.ex_alu_select}, {27'd0, c.sel});
      chk(c.id, "ex_mem_read", {31'd0, bus.ex_mem_read}, {31'd0, c.mr});
      chk(c.id, "ex_mem_write", {31'd0, bus.ex_mem_write}, {31'd0, c.mw});
      chk(c.id, "ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, c.rw});
      chk(c.id, "ex_branch", {31'd0, bus.ex_branch}, {31'd0, c.br});
      chk(c.id, "ex_jump", {31'd0, bus.ex_jump}, {31'd0, c.jp});
      chk(c.id, "ex_funct3", {29'd0, bus.ex_funct3}, {29'd0, c.f3});
      chk(c.id, "ex_wb_sel", {30'd0, bus.ex_wb_sel}, {30'd0, c.wb});
    end
  end
  initial begin
    int n;
    s = '{default: '0};
    s.rst = 1'b1;
    apply(s);
    repeat (2) @(posedge clk);
    // ADD x3 = x1 + x2
    s = '{default: '0}; s.valid = 1; s.pc = 32'h40; s.rs1 = 1; s.rs2 = 2; s.rd = 3; s.rs1d = 32'h11; s.rs2d = 32'h22; s.sel = 2; s.rw = 1; s.wb = 1;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h40; e.d1 = 32'h11; e.d2 = 32'h22; e.rs2d = 32'h22; e.rs1 = 1; e.rs2 = 2; e.rd = 3; e.sel = 2; e.rw = 1; e.wb = 1;
    drive();
    // reset wins over stall
    s.rst = 1; s.stall = 1;
    e = '{default: '0};
    drive();
    // PC / imm operand select
    s = '{default: '0}; s.valid = 1; s.pc = 32'h100; s.imm = 32'h10; s.op1 = 1; s.op2 = 1; s.sel = 1; s.rs1 = 4; s.rs1d = 32'h99; s.rs2 = 6; s.rs2d = 32'h77; s.rd = 8; s.rw = 1; s.br = 1; s.f3 = 1;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h100; e.imm = 32'h10; e.d1 = 32'h100; e.d2 = 32'h10; e.rs2d = 32'h77; e.rs1 = 4; e.rs2 = 6; e.rd = 8; e.sel = 1; e.rw = 1; e.br = 1; e.f3 = 1;
    drive();
    // WB write-through into rs1
    s = '{default: '0}; s.valid = 1; s.pc = 32'h104; s.rs1 = 5; s.rs1d = 1; s.rs2 = 6; s.rs2d = 2; s.rd = 9; s.rw = 1; s.wbw = 1; s.wbrd = 5; s.wbd = 32'hDEAD;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h104; e.d1 = 32'hDEAD; e.d2 = 2; e.rs2d = 2; e.rs1 = 5; e.rs2 = 6; e.rd = 9; e.rw = 1;
    drive();
    // WB to x0 does not forward
    s.wbrd = 0; e.d1 = 1;
    drive();
    // WB not writing does not forward
    s.wbrd = 5; s.wbw = 0;
    drive();
    // rs2 write-through: raw copy forwarded, operand still imm
    s.wbw = 1; s.wbrd = 6; s.op2 = 1; s.imm = 32'h30;
    e.imm = 32'h30; e.d2 = 32'h30; e.rs2d = 32'hDEAD;
    drive();
    // LW x7
    s = '{default: '0}; s.valid = 1; s.pc = 32'h200; s.rs1 = 2; s.rs1d = 32'h1000; s.imm = 4; s.op2 = 1; s.rd = 7; s.mr = 1; s.rw = 1; s.f3 = 2; s.wb = 2; s.sel = 2;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h200; e.imm = 4; e.d1 = 32'h1000; e.d2 = 4; e.rs1 = 2; e.rd = 7; e.sel = 2; e.mr = 1; e.rw = 1; e.f3 = 2; e.wb = 2;
    drive();
    // SW using x7 as rs2: hazard, bubble
    s = '{default: '0}; s.valid = 1; s.pc = 32'h204; s.rs1 = 1; s.rs1d = 32'h500; s.rs2 = 7; s.rs2d = 32'hAAAA; s.imm = 8; s.op2 = 1; s.mw = 1; s.f3 = 2; s.sel = 2;
    e = '{default: '0}; e.hz = 1;
    drive();
    // same SW re-presented: captured
    e = '{default: '0}; e.valid = 1; e.pc = 32'h204; e.imm = 8; e.d1 = 32'h500; e.d2 = 8; e.rs2d = 32'hAAAA; e.rs1 = 1; e.rs2 = 7; e.sel = 2; e.mw = 1; e.f3 = 2;
    drive();
    // LW x7 again
    s = '{default: '0}; s.valid = 1; s.pc = 32'h208; s.rs1 = 2; s.rs1d = 32'h1000; s.imm = 4; s.op2 = 1; s.rd = 7; s.mr = 1; s.rw = 1; s.f3 = 2; s.wb = 2; s.sel = 2;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h208; e.imm = 4; e.d1 = 32'h1000; e.d2 = 4; e.rs1 = 2; e.rd = 7; e.sel = 2; e.mr = 1; e.rw = 1; e.f3 = 2; e.wb = 2;
    drive();
    // dependent on rs1 while stalled: hazard stays up, load held
    s = '{default: '0}; s.stall = 1; s.valid = 1; s.pc = 32'h20C; s.rs1 = 7; s.rs2 = 1; s.rs1d = 1; s.imm = 8; s.op2 = 1; s.mw = 1; s.f3 = 2;
    e.hz = 1;
    drive();
    // flush with stall and hazard: bubble
    s.flush = 1;
    e = '{default: '0}; e.hz = 1;
    drive();
    // entry using x3 as rs2
    s = '{default: '0}; s.valid = 1; s.pc = 32'h300; s.imm = 5; s.rs1 = 1; s.rs1d = 32'h10; s.rs2 = 3; s.rs2d = 32'h20; s.rd = 4; s.sel = 3; s.rw = 1;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h300; e.imm = 5; e.d1 = 32'h10; e.d2 = 32'h20; e.rs2d = 32'h20; e.rs1 = 1; e.rs2 = 3; e.rd = 4; e.sel = 3; e.rw = 1;
    drive();
    // stalled, WB writes x3: rs2 refreshed
    s = '{default: '0}; s.stall = 1; s.valid = 1; s.pc = 32'h999; s.rs1 = 3; s.rs1d = 32'h77; s.wbw = 1; s.wbrd = 3; s.wbd = 32'h55;
    e.d2 = 32'h55; e.rs2d = 32'h55;
    drive();
    // stalled, WB writes x1: rs1 refreshed
    s.wbrd = 1; s.wbd = 32'h66;
    e.d1 = 32'h66;
    drive();
    // flush with stall: bubble
    s.flush = 1;
    e = '{default: '0};
    drive();
    // x0 destination drops reg_write
    s = '{default: '0}; s.valid = 1; s.pc = 32'h400; s.rs1 = 1; s.rs1d = 3; s.rs2 = 2; s.rs2d = 4; s.rw = 1; s.sel = 2; s.jp = 1; s.wb = 3;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h400; e.d1 = 3; e.d2 = 4; e.rs2d = 4; e.rs1 = 1; e.rs2 = 2; e.sel = 2; e.jp = 1; e.wb = 3;
    drive();
    // empty decode slot: bubble
    s.valid = 0;
    e = '{default: '0};
    drive();
    // load into x0
    s = '{default: '0}; s.valid = 1; s.pc = 32'h500; s.rs1 = 2; s.rs1d = 8; s.imm = 4; s.op2 = 1; s.mr = 1; s.rw = 1; s.f3 = 2; s.wb = 2;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h500; e.imm = 4; e.d1 = 8; e.d2 = 4; e.rs1 = 2; e.mr = 1; e.f3 = 2; e.wb = 2;
    drive();
    // reader of x0 after load to x0: no hazard
    s = '{default: '0}; s.valid = 1; s.pc = 32'h504; s.rd = 5; s.rw = 1;
    e = '{default: '0}; e.valid = 1; e.pc = 32'h504; e.rd = 5; e.rw = 1;
    drive();
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
